// File: rtl/mem_1r1w_mbist_ctrl_if.sv
// Read/write port bundle between the March C- sequencer and one 1R1W SRAM wrapper.
interface mem_1r1w_mbist_ctrl_if #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned WIDTH  = 64
);
    logic [ADDR_W-1:0] R0_addr;
    logic              R0_en;
    logic [WIDTH-1:0]  R0_data;
    logic [ADDR_W-1:0] W0_addr;
    logic              W0_en;
    logic [WIDTH-1:0]  W0_data;

    modport master (
        output R0_addr, R0_en, W0_addr, W0_en, W0_data,
        input  R0_data
    );

    modport slave (
        input  R0_addr, R0_en, W0_addr, W0_en, W0_data,
        output R0_data
    );
endinterface

// File: rtl/mem_1r1w_mbist_ctrl.sv
// March C- BIST sequencer for a 1R1W SRAM: {up w0}{up r0w1}{up r1w0}{dn r0w1}{dn r1w0}{dn r0}.
// Reads run one address ahead of writes; the compare of a word happens as its write is issued.
module mem_1r1w_mbist_ctrl #(
    parameter int unsigned DEPTH        = 48,
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned ADDR_W       = 6,
    parameter int unsigned STOP_ON_FAIL = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  fail,
    output logic [ADDR_W-1:0]     fail_addr,
    output logic [2:0]            fail_elem,
    mem_1r1w_mbist_ctrl_if.master mem
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Element states encode their March element number so it can be latched directly.
    typedef enum logic [2:0] {
        S_E0   = 3'd0,
        S_E1   = 3'd1,
        S_E2   = 3'd2,
        S_E3   = 3'd3,
        S_E4   = 3'd4,
        S_E5   = 3'd5,
        S_IDLE = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  idx, idx_nxt;
    logic              start_ok, mismatch;
    logic [ADDR_W-1:0] cmp_addr;
    logic              r_en_nxt, w_en_nxt, w_bit_nxt;
    logic [ADDR_W-1:0] r_addr_nxt, w_addr_nxt;

    function automatic logic is_down(state_t s);
        return (s == S_E3) || (s == S_E4) || (s == S_E5);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_of(state_t s, logic [CNT_W-1:0] i);
        return is_down(s) ? ADDR_W'(DEPTH - 1) - ADDR_W'(i) : ADDR_W'(i);
    endfunction

    // Value expected on reads in this element (r1 in E2/E4, r0 elsewhere).
    function automatic logic exp_bit(state_t s);
        return (s == S_E2) || (s == S_E4);
    endfunction

    function automatic state_t next_elem(state_t s);
        case (s)
            S_E1:    return S_E2;
            S_E2:    return S_E3;
            S_E3:    return S_E4;
            S_E4:    return S_E5;
            default: return S_DONE;
        endcase
    endfunction

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        start_ok   = 1'b0;
        mismatch   = 1'b0;
        cmp_addr   = '0;
        r_en_nxt   = 1'b0;
        r_addr_nxt = '0;
        w_en_nxt   = 1'b0;
        w_addr_nxt = '0;
        w_bit_nxt  = 1'b0;

        // Check the word whose read was issued last cycle.
        if (state != S_IDLE && state != S_DONE && state != S_E0 && idx != '0) begin
            cmp_addr = addr_of(state, idx - CNT_W'(1));
            mismatch = (mem.R0_data != {WIDTH{exp_bit(state)}});
        end

        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = S_E0;
                    idx_nxt   = '0;
                end
            end
            S_E0: begin
                if (idx == LAST) begin
                    state_nxt = S_E1;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + CNT_W'(1);
                end
            end
            default: begin
                if (idx == DEPTH_C) begin
                    state_nxt = next_elem(state);
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + CNT_W'(1);
                end
            end
        endcase

        if (STOP_ON_FAIL != 0 && mismatch) begin
            state_nxt = S_DONE;
            idx_nxt   = '0;
        end

        // Port activity for the upcoming cycle, registered below.
        case (state_nxt)
            S_E0: begin
                w_en_nxt   = 1'b1;
                w_addr_nxt = addr_of(S_E0, idx_nxt);
            end
            S_E1, S_E2, S_E3, S_E4, S_E5: begin
                if (idx_nxt != DEPTH_C) begin
                    r_en_nxt   = 1'b1;
                    r_addr_nxt = addr_of(state_nxt, idx_nxt);
                end
                if (state_nxt != S_E5 && idx_nxt != '0) begin
                    w_en_nxt   = 1'b1;
                    w_addr_nxt = addr_of(state_nxt, idx_nxt - CNT_W'(1));
                    w_bit_nxt  = ~exp_bit(state_nxt);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            fail_addr   <= '0;
            fail_elem   <= '0;
            mem.R0_en   <= 1'b0;
            mem.R0_addr <= '0;
            mem.W0_en   <= 1'b0;
            mem.W0_addr <= '0;
            mem.W0_data <= '0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            busy        <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
            done        <= (state_nxt == S_DONE);
            mem.R0_en   <= r_en_nxt;
            mem.R0_addr <= r_addr_nxt;
            mem.W0_en   <= w_en_nxt;
            mem.W0_addr <= w_addr_nxt;
            mem.W0_data <= {WIDTH{w_bit_nxt}};
            if (start_ok) begin
                fail      <= 1'b0;
                fail_addr <= '0;
                fail_elem <= '0;
            end else if (mismatch && !fail) begin
                fail      <= 1'b1;
                fail_addr <= cmp_addr;
                fail_elem <= 3'(state);
            end
        end
    end
endmodule

// File: tb/tb_mem_1r1w_mbist_ctrl.sv
// Directed bench: two sequencers (run-to-completion and stop-on-fail) each driving a behavioural SRAM with injectable faults.
module tb_mem_1r1w_mbist_ctrl;
    localparam int unsigned DEPTH  = 48;
    localparam int unsigned WIDTH  = 64;
    localparam int unsigned ADDR_W = 6;
    localparam int RUN_LEN  = 6 * DEPTH + 6;           // done appears at start cycle + 294
    localparam int STOP_LEN = (1 + DEPTH + DEPTH + 1) + 17 + 2; // E2 compare of addr 17, then one more cycle

    logic clk, reset, start0, start1;
    logic busy0, done0, fail0, busy1, done1, fail1;
    logic [ADDR_W-1:0] fail_addr0, fail_addr1;
    logic [2:0] fail_elem0, fail_elem1;

    mem_1r1w_mbist_ctrl_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) if0 ();
    mem_1r1w_mbist_ctrl_if #(.ADDR_W(ADDR_W), .WIDTH(WIDTH)) if1 ();

    mem_1r1w_mbist_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .STOP_ON_FAIL(0)) u_dut0 (
        .clock(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .fail(fail0), .fail_addr(fail_addr0), .fail_elem(fail_elem0), .mem(if0));

    mem_1r1w_mbist_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .ADDR_W(ADDR_W), .STOP_ON_FAIL(1)) u_dut1 (
        .clock(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .fail(fail1), .fail_addr(fail_addr1), .fail_elem(fail_elem1), .mem(if1));

    int tests, fails;
    int fault0;               // 0 none, 1 addr17 bit5 stuck-at-0, 2 addr3 1->0 write flips addr2
    logic mem_clr, mon_clr;
    int wr_cnt, rd_cnt, coll_cnt;
    logic [WIDTH-1:0] mem0 [2**ADDR_W];
    logic [WIDTH-1:0] mem1 [2**ADDR_W];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: synchronous read (old data), then write with fault injection.
    always @(posedge clk) begin
        logic [WIDTH-1:0] wd;
        if (mem_clr) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem0[i] = '0;
                mem1[i] = '0;
            end
        end else begin
            if (if0.R0_en) if0.R0_data <= mem0[if0.R0_addr];
            if (if1.R0_en) if1.R0_data <= mem1[if1.R0_addr];
            if (if0.W0_en) begin
                wd = if0.W0_data;
                if (fault0 == 1 && if0.W0_addr == 6'd17) wd[5] = 1'b0;
                if (fault0 == 2 && if0.W0_addr == 6'd3 && mem0[3][0] && !wd[0]) mem0[2] = ~mem0[2];
                mem0[if0.W0_addr] = wd;
            end
            if (if1.W0_en) begin
                wd = if1.W0_data;
                if (if1.W0_addr == 6'd17) wd[5] = 1'b0;
                mem1[if1.W0_addr] = wd;
            end
        end
    end

    always @(posedge clk) begin
        if (mon_clr) begin
            wr_cnt = 0; rd_cnt = 0; coll_cnt = 0;
        end else begin
            if (if0.W0_en) wr_cnt++;
            if (if0.R0_en) rd_cnt++;
            if (if0.R0_en && if0.W0_en && if0.R0_addr == if0.W0_addr) coll_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem_mon();
        mem_clr = 1'b1; mon_clr = 1'b1;
        tick();
        mem_clr = 1'b0; mon_clr = 1'b0;
    endtask

    // Pulse start0 for one cycle; n = cycles from the start cycle to done, -1 on timeout.
    task automatic run0(output int n);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        n = 1;
        while (!done0 && n < 1000) begin tick(); n++; end
        if (!done0) n = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tests++;
        if ({busy0, done0, fail0, fail_addr0, fail_elem0} !== '0) begin
            fails++; $display("FAIL reset_status0: got %b required 0", {busy0, done0, fail0, fail_addr0, fail_elem0});
        end
        tests++;
        if ({if0.R0_en, if0.W0_en, if0.R0_addr, if0.W0_addr} !== '0 || if0.W0_data !== '0) begin
            fails++; $display("FAIL reset_mem0: got en=%b%b raddr=%0d waddr=%0d required 0", if0.R0_en, if0.W0_en, if0.R0_addr, if0.W0_addr);
        end
        tests++;
        if ({busy1, done1, fail1, if1.R0_en, if1.W0_en} !== '0) begin
            fails++; $display("FAIL reset_dut1: got %b required 0", {busy1, done1, fail1, if1.R0_en, if1.W0_en});
        end
    endtask

    task automatic test_clean_run();
        int n;
        fault0 = 0;
        clear_mem_mon();
        tick();
        run0(n);
        tests++;
        if (n !== RUN_LEN) begin fails++; $display("FAIL clean_done_cycle: got %0d required %0d", n, RUN_LEN); end
        tests++;
        if (fail0 !== 1'b0 || busy0 !== 1'b0) begin fails++; $display("FAIL clean_status: got fail=%b busy=%b required 0 0", fail0, busy0); end
        tests++;
        if (wr_cnt !== 5 * DEPTH) begin fails++; $display("FAIL clean_writes: got %0d required %0d", wr_cnt, 5 * DEPTH); end
        tests++;
        if (rd_cnt !== 5 * DEPTH) begin fails++; $display("FAIL clean_reads: got %0d required %0d", rd_cnt, 5 * DEPTH); end
        tests++;
        if (coll_cnt !== 0) begin fails++; $display("FAIL clean_collisions: got %0d required 0", coll_cnt); end
        tick(); tick(); tick();
        tests++;
        if (done0 !== 1'b1 || if0.R0_en !== 1'b0 || if0.W0_en !== 1'b0) begin
            fails++; $display("FAIL done_held: got done=%b en=%b%b required 1 00", done0, if0.R0_en, if0.W0_en);
        end
    endtask

    task automatic test_stuck_at();
        int n;
        fault0 = 1;
        clear_mem_mon();
        run0(n);
        tests++;
        if (n !== RUN_LEN) begin fails++; $display("FAIL stuck_done_cycle: got %0d required %0d", n, RUN_LEN); end
        tests++;
        if (fail0 !== 1'b1 || fail_elem0 !== 3'd2 || fail_addr0 !== 6'd17) begin
            fails++; $display("FAIL stuck_capture: got fail=%b elem=%0d addr=%0d required 1 2 17", fail0, fail_elem0, fail_addr0);
        end
    endtask

    task automatic test_coupling();
        int n;
        fault0 = 2;
        clear_mem_mon();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tests++;
        if (fail0 !== 1'b0 || done0 !== 1'b0 || busy0 !== 1'b1) begin
            fails++; $display("FAIL restart_clears: got fail=%b done=%b busy=%b required 0 0 1", fail0, done0, busy0);
        end
        n = 1;
        while (!done0 && n < 1000) begin tick(); n++; end
        tests++;
        if (n !== RUN_LEN) begin fails++; $display("FAIL coupling_done_cycle: got %0d required %0d", n, RUN_LEN); end
        tests++;
        if (fail0 !== 1'b1 || fail_elem0 !== 3'd3 || fail_addr0 !== 6'd2) begin
            fails++; $display("FAIL coupling_capture: got fail=%b elem=%0d addr=%0d required 1 3 2", fail0, fail_elem0, fail_addr0);
        end
    endtask

    task automatic test_stop_on_fail();
        int n, act;
        clear_mem_mon();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        n = 1;
        while (!done1 && n < 1000) begin tick(); n++; end
        tests++;
        if (n !== STOP_LEN || busy1 !== 1'b0) begin
            fails++; $display("FAIL stop_cycle: got %0d busy=%b required %0d busy=0", n, busy1, STOP_LEN);
        end
        tests++;
        if (fail1 !== 1'b1 || fail_elem1 !== 3'd2 || fail_addr1 !== 6'd17) begin
            fails++; $display("FAIL stop_capture: got fail=%b elem=%0d addr=%0d required 1 2 17", fail1, fail_elem1, fail_addr1);
        end
        act = 0;
        for (int i = 0; i < 6; i++) begin
            if (if1.R0_en || if1.W0_en) act++;
            tick();
        end
        tests++;
        if (act !== 0) begin fails++; $display("FAIL stop_enables: got %0d active cycles required 0", act); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        fault0 = 0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 1; i < 100; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if ({busy0, done0, fail0, fail_addr0, fail_elem0, if0.R0_en, if0.W0_en, if0.R0_addr, if0.W0_addr} !== '0
            || if0.W0_data !== '0) begin
            fails++; $display("FAIL midrun_reset: got busy=%b done=%b en=%b%b required all 0", busy0, done0, if0.R0_en, if0.W0_en);
        end
        clear_mem_mon();
        run0(n);
        tests++;
        if (n !== RUN_LEN || fail0 !== 1'b0 || wr_cnt !== 5 * DEPTH || rd_cnt !== 5 * DEPTH) begin
            fails++; $display("FAIL rerun_after_reset: got n=%0d fail=%b wr=%0d rd=%0d required %0d 0 %0d %0d",
                              n, fail0, wr_cnt, rd_cnt, RUN_LEN, 5 * DEPTH, 5 * DEPTH);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        fault0 = 0;
        start0 = 1'b1;
        tick();
        n = 1;
        while (!done0 && n < 1000) begin tick(); n++; end
        tests++;
        if (n !== RUN_LEN || busy0 !== 1'b0) begin
            fails++; $display("FAIL held_start_done: got %0d busy=%b required %0d busy=0", n, busy0, RUN_LEN);
        end
        tick();
        tests++;
        if (busy0 !== 1'b1 || done0 !== 1'b0) begin
            fails++; $display("FAIL held_start_restart: got busy=%b done=%b required 1 0", busy0, done0);
        end
        start0 = 1'b0;
        n = 1;
        while (!done0 && n < 1000) begin tick(); n++; end
        tests++;
        if (n !== RUN_LEN || fail0 !== 1'b0) begin
            fails++; $display("FAIL held_start_second_run: got %0d fail=%b required %0d 0", n, fail0, RUN_LEN);
        end
    endtask

    initial begin
        tests = 0; fails = 0;
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        fault0 = 0; mem_clr = 1'b0; mon_clr = 1'b0;
        if0.R0_data = '0; if1.R0_data = '0;
        test_reset();
        test_clean_run();
        test_stuck_at();
        test_coupling();
        test_stop_on_fail();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
